// File: rtl/cache_bus_pkg.sv
// Shared types for the cache-side burst bus arbiter: FSM states, owner tags and width defaults.
package cache_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        WRESP = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter for one burst: cleared on load, advanced per beat, flags the beat whose index equals len.
module burst_beat_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             is_last
);

    logic [LEN_W-1:0] r_count;

    // Natural wrap after the 16th beat is harmless: load clears before the next burst.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign is_last = (r_count == len);

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates the single external burst port between I-cache refills and D-cache refills/write-backs,
// one transaction outstanding at a time.
import cache_bus_pkg::*;

module cache_bus_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic              i_rlast,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic [DATA_W-1:0] d_rdata,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic              d_bdone,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LEN_W-1:0]  m_len,
    input  logic              m_ack,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_wvalid,
    output logic              m_wlast,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_wready,
    input  logic              m_bvalid
);

    // Handshakes: a beat moves on a cycle where its valid and its ready are both high;
    // requests are levels held until the matching 1-cycle gnt pulse.

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    owner_t            r_owner;
    logic              r_last_d;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;

    logic w_any_req;
    logic w_pick_d;
    logic w_cnt_load;
    logic w_cnt_inc;
    logic w_is_last;

    assign w_any_req = i_req | d_req;
    // D has priority, except that I goes first when D held the previous grant.
    assign w_pick_d  = d_req & ~(r_last_d & i_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= OWN_I;
            r_last_d <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_any_req) begin
                r_owner  <= w_pick_d ? OWN_D : OWN_I;
                r_last_d <= w_pick_d;
                r_we     <= w_pick_d & d_we;
                r_addr   <= w_pick_d ? d_addr : i_addr;
                r_len    <= w_pick_d ? d_len : i_len;
            end
        end
    end

    burst_beat_counter #(.LEN_W(LEN_W)) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (w_cnt_load),
        .inc     (w_cnt_inc),
        .len     (r_len),
        .is_last (w_is_last)
    );

    assign m_we   = r_we;
    assign m_addr = r_addr;
    assign m_len  = r_len;

    always_comb begin
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_inc    = 1'b0;
        m_req        = 1'b0;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        i_rlast      = 1'b0;
        i_rdata      = '0;
        d_rvalid     = 1'b0;
        d_rlast      = 1'b0;
        d_rdata      = '0;
        d_wready     = 1'b0;
        d_bdone      = 1'b0;
        m_wvalid     = 1'b0;
        m_wlast      = 1'b0;
        m_wdata      = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) w_next_state = ADDR;
            end
            ADDR: begin
                m_req = 1'b1;
                if (m_ack) begin
                    i_gnt        = (r_owner == OWN_I);
                    d_gnt        = (r_owner == OWN_D);
                    w_cnt_load   = 1'b1;
                    w_next_state = r_we ? WDATA : RDATA;
                end
            end
            RDATA: begin
                // The local beat count, not m_rlast, decides where the burst ends.
                if (m_rvalid) begin
                    w_cnt_inc = 1'b1;
                    if (r_owner == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rlast  = w_is_last;
                        d_rdata  = m_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rlast  = w_is_last;
                        i_rdata  = m_rdata;
                    end
                    if (w_is_last) w_next_state = IDLE;
                end
            end
            WDATA: begin
                m_wvalid = 1'b1;
                m_wlast  = w_is_last;
                m_wdata  = d_wdata;
                d_wready = m_wready;
                if (m_wready) begin
                    w_cnt_inc = 1'b1;
                    if (w_is_last) w_next_state = WRESP;
                end
            end
            WRESP: begin
                d_bdone = m_bvalid;
                if (m_bvalid) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    a_rlast_matches_count: assert property (@(posedge clk) disable iff (rst)
        (r_state == RDATA && m_rvalid) |-> (m_rlast == w_is_last))
        else $warning("m_rlast disagrees with the beat counter; counter decides the last beat");

    a_req_held_until_gnt: assert property (@(posedge clk) disable iff (rst)
        (r_state == ADDR) |-> ((r_owner == OWN_D) ? d_req : i_req))
        else $error("requester dropped req before its grant");
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_cache_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic rst;
  logic i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LEN_W-1:0] i_len, d_len;
  logic [DATA_W-1:0] d_wdata, m_rdata;
  logic m_ack, m_rvalid, m_rlast, m_wready, m_bvalid;
  logic i_gnt, i_rvalid, i_rlast, d_gnt, d_rvalid, d_rlast, d_wready, d_bdone;
  logic m_req, m_we, m_wvalid, m_wlast;
  logic [DATA_W-1:0] i_rdata, d_rdata, m_wdata;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0] m_len;

  cache_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
    .d_wdata(d_wdata), .d_wready(d_wready), .d_bdone(d_bdone),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_ack(m_ack),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata),
    .m_wready(m_wready), .m_bvalid(m_bvalid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  bit rst_q;

  // transaction model: who owns the bus, what phase the transaction is in, beats done so far
  localparam int PH_ADDR = 0;
  localparam int PH_DATA = 1;
  localparam int PH_RESP = 2;
  bit mdl_act, mdl_own_d, mdl_we, mdl_last_d;
  logic [ADDR_W-1:0] mdl_addr;
  int mdl_len, mdl_phase, mdl_beat;

  // observations of DUT activity, pinned against literals after each scenario
  int i_gnt_cnt, d_gnt_cnt, i_rv_cnt, i_rlast_cnt, i_rlast_at;
  int d_rv_cnt, d_rlast_cnt, d_rlast_at, w_acc, wlast_cnt, wlast_at, bdone_cnt, d_any;
  bit grant_log[$];
  bit saw_i_gnt, saw_d_gnt;
  int i_want, d_want;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT at %0t", nm, $time);
  endtask

  task automatic clear_obs();
    i_gnt_cnt = 0; d_gnt_cnt = 0; i_rv_cnt = 0; i_rlast_cnt = 0; i_rlast_at = 0;
    d_rv_cnt = 0; d_rlast_cnt = 0; d_rlast_at = 0; w_acc = 0; wlast_cnt = 0;
    wlast_at = 0; bdone_cnt = 0; d_any = 0;
    grant_log.delete();
  endtask

  // ---------------- per-cycle compare and model step ----------------
  task automatic compare_cycle();
    logic e_mreq, e_igt, e_dgt, e_irv, e_irl, e_drv, e_drl, e_wv, e_wl, e_wr, e_bd;
    logic [DATA_W-1:0] e_ird, e_drd, e_wd;
    bit own_d;
    saw_i_gnt = i_gnt;
    saw_d_gnt = d_gnt;
    if (i_gnt) begin i_gnt_cnt++; grant_log.push_back(1'b0); end
    if (d_gnt) begin d_gnt_cnt++; grant_log.push_back(1'b1); end
    if (i_rvalid) begin
      i_rv_cnt++;
      if (i_rlast) begin i_rlast_cnt++; i_rlast_at = i_rv_cnt; end
    end
    if (d_rvalid) begin
      d_rv_cnt++;
      if (d_rlast) begin d_rlast_cnt++; d_rlast_at = d_rv_cnt; end
    end
    if (m_wvalid && m_wready) begin
      w_acc++;
      if (m_wlast) begin wlast_cnt++; wlast_at = w_acc; end
    end
    if (d_bdone) bdone_cnt++;
    if (d_gnt || d_rvalid || d_rlast || (d_rdata != '0) || d_wready || d_bdone) d_any++;

    if (rst_q) begin
      chk("rst_ctrl", {m_req, m_we, i_gnt, i_rvalid, i_rlast, d_gnt, d_rvalid, d_rlast,
                       d_wready, d_bdone, m_wvalid, m_wlast}, 64'd0);
      chk("rst_addr_len", {m_addr, m_len}, 64'd0);
      chk("rst_data", {i_rdata, d_rdata}, 64'd0);
      chk("rst_wdata", m_wdata, 64'd0);
    end else begin
      e_mreq = 0; e_igt = 0; e_dgt = 0; e_irv = 0; e_irl = 0; e_drv = 0; e_drl = 0;
      e_wv = 0; e_wl = 0; e_wr = 0; e_bd = 0; e_ird = '0; e_drd = '0; e_wd = '0;
      if (mdl_act) begin
        if (mdl_phase == PH_ADDR) begin
          e_mreq = 1'b1;
          e_igt = m_ack && !mdl_own_d;
          e_dgt = m_ack && mdl_own_d;
          chk("m_addr", m_addr, mdl_addr);
          chk("m_len", m_len, 64'(mdl_len));
          chk("m_we", m_we, mdl_we);
        end else if (mdl_phase == PH_DATA && !mdl_we) begin
          if (mdl_own_d) begin
            e_drv = m_rvalid; e_drd = m_rvalid ? m_rdata : '0; e_drl = m_rvalid && (mdl_beat == mdl_len);
          end else begin
            e_irv = m_rvalid; e_ird = m_rvalid ? m_rdata : '0; e_irl = m_rvalid && (mdl_beat == mdl_len);
          end
        end else if (mdl_phase == PH_DATA) begin
          e_wv = 1'b1; e_wl = (mdl_beat == mdl_len); e_wr = m_wready; e_wd = d_wdata;
        end else begin
          e_bd = m_bvalid;
        end
      end
      chk("m_req", m_req, e_mreq);
      chk("i_gnt", i_gnt, e_igt);
      chk("d_gnt", d_gnt, e_dgt);
      chk("i_rvalid", i_rvalid, e_irv);
      chk("i_rlast", i_rlast, e_irl);
      chk("i_rdata", i_rdata, e_ird);
      chk("d_rvalid", d_rvalid, e_drv);
      chk("d_rlast", d_rlast, e_drl);
      chk("d_rdata", d_rdata, e_drd);
      chk("m_wvalid", m_wvalid, e_wv);
      chk("m_wlast", m_wlast, e_wl);
      chk("m_wdata", m_wdata, e_wd);
      chk("d_wready", d_wready, e_wr);
      chk("d_bdone", d_bdone, e_bd);
    end

    // advance the model to what must hold next cycle
    if (rst) begin
      mdl_act = 0; mdl_last_d = 0;
    end else if (!mdl_act) begin
      if (i_req || d_req) begin
        own_d = d_req && !(mdl_last_d && i_req);
        mdl_act = 1; mdl_phase = PH_ADDR; mdl_own_d = own_d; mdl_last_d = own_d;
        mdl_we = own_d && d_we;
        mdl_addr = own_d ? d_addr : i_addr;
        mdl_len = own_d ? int'(d_len) : int'(i_len);
      end
    end else if (mdl_phase == PH_ADDR) begin
      if (m_ack) begin mdl_phase = PH_DATA; mdl_beat = 0; end
    end else if (mdl_phase == PH_DATA && !mdl_we) begin
      if (m_rvalid) begin
        if (mdl_beat == mdl_len) mdl_act = 0;
        else mdl_beat++;
      end
    end else if (mdl_phase == PH_DATA) begin
      if (m_wready) begin
        if (mdl_beat == mdl_len) mdl_phase = PH_RESP;
        else mdl_beat++;
      end
    end else begin
      if (m_bvalid) mdl_act = 0;
    end
  endtask

  // one clock cycle: inputs set before the call are in effect for this cycle
  task automatic cyc();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    rst_q = rst;
    #1;
    if (saw_i_gnt && i_want > 0) begin i_want--; if (i_want == 0) i_req = 1'b0; end
    if (saw_d_gnt && d_want > 0) begin d_want--; if (d_want == 0) d_req = 1'b0; end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; i_len = '0; d_len = '0;
    d_wdata = '0; m_rdata = '0; m_ack = 0; m_rvalid = 0; m_rlast = 0; m_wready = 0; m_bvalid = 0;
    i_want = 0; d_want = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic req_i(input logic [ADDR_W-1:0] a, input int len, input int want);
    i_addr = a; i_len = LEN_W'(len); i_want = want; i_req = 1'b1;
  endtask

  task automatic req_d(input bit we, input logic [ADDR_W-1:0] a, input int len, input int want);
    d_we = we; d_addr = a; d_len = LEN_W'(len); d_want = want; d_req = 1'b1;
  endtask

  // bus slave: accept one address phase, then move the burst it describes
  task automatic bus_serve(input int ack_wait, input bit w_toggle, input int early_last);
    int t;
    int len;
    bit we;
    bit tog;
    int b;
    m_ack = 0;
    t = 0;
    while (!m_req && t < 100) begin cyc(); t++; end
    if (!m_req) begin tmo("wait_m_req"); return; end
    repeat (ack_wait) cyc();
    len = int'(m_len);
    we = m_we;
    m_ack = 1'b1;
    cyc();
    m_ack = 1'b0;
    if (!we) begin
      for (int k = 0; k <= len; k++) begin
        m_rvalid = 1'b1;
        m_rdata = $urandom;
        m_rlast = (early_last >= 0) ? (k == early_last) : (k == len);
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        if (k == 0 && len > 0) cyc();
      end
    end else begin
      b = 0; tog = 1'b1; t = 0;
      while (b <= len && t < 64) begin
        m_wready = w_toggle ? tog : 1'b1;
        d_wdata = $urandom;
        cyc();
        if (m_wready) b++;
        tog = ~tog;
        t++;
      end
      m_wready = 1'b0;
      cyc();
      m_bvalid = 1'b1;
      cyc();
      m_bvalid = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst = 1'b1;
    @(posedge clk);
    rst_q = 1'b1;
    #1;

    // I-cache refill alone, len=3, ack in the first address cycle
    do_reset();
    clear_obs();
    req_i(32'h1FC0_0000, 3, 1);
    bus_serve(0, 1'b0, -1);
    repeat (2) cyc();
    chk("t1_i_gnt_pulses", i_gnt_cnt, 1);
    chk("t1_i_beats", i_rv_cnt, 4);
    chk("t1_i_rlast_beat", i_rlast_at, 4);
    chk("t1_d_quiet", d_any, 0);

    // D write-back len=7 with m_wready toggling
    do_reset();
    clear_obs();
    req_d(1'b1, 32'h8000_0040, 7, 1);
    bus_serve(1, 1'b1, -1);
    repeat (2) cyc();
    chk("t2_w_beats", w_acc, 8);
    chk("t2_wlast_count", wlast_cnt, 1);
    chk("t2_wlast_beat", wlast_at, 8);
    chk("t2_bdone", bdone_cnt, 1);

    // simultaneous requests, both held: D, I, D
    do_reset();
    clear_obs();
    req_i(32'h1FC0_0100, 2, 1);
    req_d(1'b0, 32'h8000_1000, 1, 2);
    repeat (3) bus_serve(0, 1'b0, -1);
    repeat (2) cyc();
    chk("t3_grant_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t3_grant0_is_d", grant_log[0], 1'b1);
      chk("t3_grant1_is_i", grant_log[1], 1'b0);
      chk("t3_grant2_is_d", grant_log[2], 1'b1);
    end

    // single-beat read then single-beat write
    clear_obs();
    req_i(32'h1FC0_0200, 0, 1);
    bus_serve(0, 1'b0, -1);
    cyc();
    chk("t4_i_beats", i_rv_cnt, 1);
    chk("t4_i_rlast_beat", i_rlast_at, 1);
    clear_obs();
    req_d(1'b1, 32'h8000_2000, 0, 1);
    bus_serve(0, 1'b0, -1);
    repeat (3) cyc();
    chk("t4_w_beats", w_acc, 1);
    chk("t4_wlast_beat", wlast_at, 1);
    chk("t4_bdone", bdone_cnt, 1);

    // reset during beat 2 of an 8-beat D refill, then a normal I refill
    do_reset();
    clear_obs();
    req_d(1'b0, 32'h8000_3000, 7, 1);
    begin
      int t = 0;
      while (!m_req && t < 100) begin cyc(); t++; end
      if (!m_req) tmo("t5_wait_m_req");
    end
    m_ack = 1'b1; cyc(); m_ack = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hA5A5_0001; cyc();
    m_rvalid = 1'b1; m_rdata = 32'hA5A5_0002; rst = 1'b1; cyc();
    m_rvalid = 1'b0; rst = 1'b0;
    cyc();
    chk("t5_d_beats_before_rst", d_rv_cnt, 2);
    clear_obs();
    req_i(32'h1FC0_0300, 3, 1);
    bus_serve(0, 1'b0, -1);
    repeat (2) cyc();
    chk("t5_i_gnt_after_rst", i_gnt_cnt, 1);
    chk("t5_i_beats_after_rst", i_rv_cnt, 4);

    // bus flags last on beat 2 of a 4-beat D refill; the count still ends the burst
    do_reset();
    clear_obs();
    req_d(1'b0, 32'h8000_4000, 3, 1);
    bus_serve(0, 1'b0, 1);
    repeat (2) cyc();
    chk("t6_d_beats", d_rv_cnt, 4);
    chk("t6_d_rlast_count", d_rlast_cnt, 1);
    chk("t6_d_rlast_beat", d_rlast_at, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
